// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and forwarding controller for a 5-stage
// IF/ID/EX/MEM/WB pipeline. Keeps a shadow record of the instructions in EX,
// MEM and WB and, from those records plus the instruction in ID, decides
// load-use stalls, multi-cycle EX holds, branch flushes and EX forwarding.
// All control outputs are combinational from registered state and ID inputs.
//
// Optional build macro: PIPE_HAZARD_CTRL_PERF_EN
//   defined   -> stall_cnt / flush_cnt are saturating 32-bit event counters
//   undefined -> both ports are tied to zero and no counter flops exist
module pipe_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 4,  // EX occupancy of a multi-cycle op, >= 1
  parameter int CNT_W   = 3   // 2**CNT_W must exceed MUL_LAT
) (
  input  logic              clk,
  input  logic              reset,        // asynchronous, active low
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_multi,
  input  logic              br_taken,
  output logic              stall_if_id,
  output logic              bubble_ex,
  output logic              hold_ex,
  output logic              bubble_mem,
  output logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  // Value loaded into the occupancy counter when a multi-cycle op enters EX;
  // the op then blocks the pipe for MUL_LAT-1 extra cycles.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

  // Forwarding select encodings.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // ------------------------------------------------------------------
  // Stage records
  // ------------------------------------------------------------------
  logic              ex_valid_reg,      ex_valid_next;
  logic [REG_AW-1:0] ex_dest_reg,       ex_dest_next;
  logic              ex_reg_write_reg,  ex_reg_write_next;
  logic              ex_mem_read_reg,   ex_mem_read_next;
  logic [REG_AW-1:0] ex_rs_reg,         ex_rs_next;
  logic [REG_AW-1:0] ex_rt_reg,         ex_rt_next;

  logic              mem_valid_reg,     mem_valid_next;
  logic [REG_AW-1:0] mem_dest_reg,      mem_dest_next;
  logic              mem_reg_write_reg, mem_reg_write_next;

  logic              wb_valid_reg,      wb_valid_next;
  logic [REG_AW-1:0] wb_dest_reg,       wb_dest_next;
  logic              wb_reg_write_reg,  wb_reg_write_next;

  logic [CNT_W-1:0]  mul_cnt_reg,       mul_cnt_next;

  // ------------------------------------------------------------------
  // Hazard detection
  // ------------------------------------------------------------------
  logic flush_act;    // branch squash this cycle (never while in reset)
  logic multi_busy;   // multi-cycle op still occupying EX
  logic load_use;     // ID needs the result of the load sitting in EX
  logic lu_rs_hit;
  logic lu_rt_hit;

  assign flush_act  = reset & br_taken;
  assign multi_busy = (mul_cnt_reg != '0);

  // A load to $0 produces nothing worth waiting for.
  assign lu_rs_hit = id_uses_rs & (id_rs == ex_dest_reg);
  assign lu_rt_hit = id_uses_rt & (id_rt == ex_dest_reg);
  assign load_use  = id_valid & ex_valid_reg & ex_mem_read_reg &
                     (ex_dest_reg != '0) & (lu_rs_hit | lu_rt_hit);

  // Stage-register controls; flush outranks a busy multiplier, which
  // outranks a load-use stall.
  always_comb begin
    stall_if_id = 1'b0;
    bubble_ex   = 1'b0;
    hold_ex     = 1'b0;
    bubble_mem  = 1'b0;
    flush       = 1'b0;
    if (flush_act) begin
      flush = 1'b1;
    end else if (multi_busy) begin
      stall_if_id = 1'b1;
      hold_ex     = 1'b1;
      bubble_mem  = 1'b1;
    end else if (load_use) begin
      stall_if_id = 1'b1;
      bubble_ex   = 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // EX operand forwarding: index 0 is rs (operand A), index 1 is rt (B)
  // ------------------------------------------------------------------
  logic [REG_AW-1:0] ex_src  [2];
  logic [1:0]        fwd_sel [2];

  assign ex_src[0] = ex_rs_reg;
  assign ex_src[1] = ex_rt_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic mem_hit;
      logic wb_hit;

      // Writes to $0 are discarded by the register file, so never forward them.
      assign mem_hit = mem_valid_reg & mem_reg_write_reg &
                       (mem_dest_reg != '0) & (mem_dest_reg == ex_src[gi]);
      assign wb_hit  = wb_valid_reg & wb_reg_write_reg &
                       (wb_dest_reg != '0) & (wb_dest_reg == ex_src[gi]);

      // The younger producer (EX/MEM) holds the most recent value.
      always_comb begin
        fwd_sel[gi] = FWD_RF;
        if (ex_valid_reg) begin
          if (mem_hit) begin
            fwd_sel[gi] = FWD_MEM;
          end else if (wb_hit) begin
            fwd_sel[gi] = FWD_WB;
          end
        end
      end
    end
  endgenerate

  assign fwd_a = fwd_sel[0];
  assign fwd_b = fwd_sel[1];

  // ------------------------------------------------------------------
  // Next-state for the shadow pipeline
  // ------------------------------------------------------------------
  // Shadow records advance exactly as the real stage registers do under the
  // controls chosen above.
  always_comb begin
    // WB always takes whatever leaves MEM, including bubbles.
    wb_valid_next      = mem_valid_reg;
    wb_dest_next       = mem_dest_reg;
    wb_reg_write_next  = mem_reg_write_reg;

    // Default: MEM takes EX, EX takes ID.
    mem_valid_next     = ex_valid_reg;
    mem_dest_next      = ex_dest_reg;
    mem_reg_write_next = ex_reg_write_reg;

    ex_valid_next      = id_valid;
    ex_dest_next       = id_dest;
    ex_reg_write_next  = id_reg_write;
    ex_mem_read_next   = id_mem_read;
    ex_rs_next         = id_rs;
    ex_rt_next         = id_rt;

    mul_cnt_next       = (id_valid & id_multi) ? MUL_LOAD : '0;

    if (flush_act) begin
      // Squash everything younger than MEM; an in-flight multiply dies too.
      ex_valid_next  = 1'b0;
      mem_valid_next = 1'b0;
      mul_cnt_next   = '0;
    end else if (multi_busy) begin
      // Multiply keeps EX; a bubble trails into MEM.
      ex_valid_next      = ex_valid_reg;
      ex_dest_next       = ex_dest_reg;
      ex_reg_write_next  = ex_reg_write_reg;
      ex_mem_read_next   = ex_mem_read_reg;
      ex_rs_next         = ex_rs_reg;
      ex_rt_next         = ex_rt_reg;
      mem_valid_next     = 1'b0;
      mul_cnt_next       = mul_cnt_reg - 1'b1;
    end else if (load_use) begin
      // Load advances to MEM, a bubble enters EX, ID waits one cycle.
      ex_valid_next = 1'b0;
      mul_cnt_next  = '0;
    end
  end

  // Register the shadow pipeline; reset empties every stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_reg      <= 1'b0;
      ex_dest_reg       <= '0;
      ex_reg_write_reg  <= 1'b0;
      ex_mem_read_reg   <= 1'b0;
      ex_rs_reg         <= '0;
      ex_rt_reg         <= '0;
      mem_valid_reg     <= 1'b0;
      mem_dest_reg      <= '0;
      mem_reg_write_reg <= 1'b0;
      wb_valid_reg      <= 1'b0;
      wb_dest_reg       <= '0;
      wb_reg_write_reg  <= 1'b0;
      mul_cnt_reg       <= '0;
    end else begin
      ex_valid_reg      <= ex_valid_next;
      ex_dest_reg       <= ex_dest_next;
      ex_reg_write_reg  <= ex_reg_write_next;
      ex_mem_read_reg   <= ex_mem_read_next;
      ex_rs_reg         <= ex_rs_next;
      ex_rt_reg         <= ex_rt_next;
      mem_valid_reg     <= mem_valid_next;
      mem_dest_reg      <= mem_dest_next;
      mem_reg_write_reg <= mem_reg_write_next;
      wb_valid_reg      <= wb_valid_next;
      wb_dest_reg       <= wb_dest_next;
      wb_reg_write_reg  <= wb_reg_write_next;
      mul_cnt_reg       <= mul_cnt_next;
    end
  end

  // ------------------------------------------------------------------
  // Performance counters
  // ------------------------------------------------------------------
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_reg, stall_cnt_next;
  logic [31:0] flush_cnt_reg, flush_cnt_next;

  // Saturating increments so a long run never wraps back to small values.
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    if (stall_if_id && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_next = stall_cnt_reg + 32'd1;
    end
    if (flush && (flush_cnt_reg != 32'hFFFF_FFFF)) begin
      flush_cnt_next = flush_cnt_reg + 32'd1;
    end
  end

  // Counter registers, cleared with the rest of the controller.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule
